// File: rtl/branch_outcome_sequencer_pkg.sv
// Shared branch definitions: entry layout, sequencer state and tag width.
// The tag width here also sets the predictor FIFO depth.
package branch_outcome_sequencer_pkg;

   localparam int BRANCH_TAG_DEPTH = 4;
   localparam int BRANCH_TAG_BITS  = $clog2(BRANCH_TAG_DEPTH);

   // One in-flight branch: allocated, outcome known, outcome value
   typedef struct packed {
      logic valid_alloc;
      logic resolved;
      logic taken;
   } branch_entry_t;

   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_FLUSH = 1'b1
   } seq_state_t;

endpackage

// File: rtl/branch_outcome_sequencer_table.sv
// Per-tag outcome table: an allocate write, a resolve write, a retire clear
// of the head entry, a head read and a resolve-side lookup. The synchronous
// clear discards every entry (wrong-path flush) and beats all other writes.
module branch_outcome_sequencer_table
   import branch_outcome_sequencer_pkg::*;
#(
   parameter int TAG_DEPTH = BRANCH_TAG_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clr_i,
   input  logic                         alloc_we_i,
   input  logic [$clog2(TAG_DEPTH)-1:0] alloc_idx_i,
   input  logic                         res_we_i,
   input  logic [$clog2(TAG_DEPTH)-1:0] res_idx_i,
   input  logic                         res_taken_i,
   input  logic                         ret_we_i,
   input  logic [$clog2(TAG_DEPTH)-1:0] head_idx_i,
   output branch_entry_t                head_o,
   output logic                         res_valid_o,
   output logic                         res_resolved_o
);

   branch_entry_t entry_q [TAG_DEPTH];
   branch_entry_t entry_d [TAG_DEPTH];

   // Reads for the retire path and for qualifying an incoming resolve
   always_comb begin
      head_o         = entry_q[head_idx_i];
      res_valid_o    = entry_q[res_idx_i].valid_alloc;
      res_resolved_o = entry_q[res_idx_i].resolved;
   end

   // Next table contents; the three write ports never target the same entry
   always_comb begin
      entry_d = entry_q;
      if (clr_i) begin
         for (int i = 0; i < TAG_DEPTH; i++) entry_d[i] = '0;
      end else begin
         if (alloc_we_i) entry_d[alloc_idx_i] = '{valid_alloc: 1'b1, resolved: 1'b0, taken: 1'b0};
         if (res_we_i) begin
            entry_d[res_idx_i].resolved = 1'b1;
            entry_d[res_idx_i].taken    = res_taken_i;
         end
         if (ret_we_i) entry_d[head_idx_i] = '0;
      end
   end

   // Table storage register
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < TAG_DEPTH; i++) entry_q[i] <= '0;
      end else begin
         entry_q <= entry_d;
      end
   end

endmodule

// File: rtl/branch_outcome_sequencer.sv
// Branch outcome sequencer: tags predictions, accepts out-of-order outcomes,
// replays them in program order to the predictor and flushes on mispredict.
// Optional feature macro: BRANCH_STATS_EN (retired / mispredict counters).
// Handshake: alloc_i is accepted only in a cycle where full_o is low;
// executed_o is a one-cycle strobe with no back-pressure.
module branch_outcome_sequencer
   import branch_outcome_sequencer_pkg::*;
#(
   parameter int TAG_DEPTH = BRANCH_TAG_DEPTH
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         alloc_i,
   output logic [$clog2(TAG_DEPTH)-1:0] alloc_tag_o,
   output logic                         full_o,
   input  logic                         resolve_i,
   input  logic [$clog2(TAG_DEPTH)-1:0] resolve_tag_i,
   input  logic                         resolve_taken_i,
   output logic                         executed_o,
   output logic                         taken_o,
   input  logic                         mispredicted_i,
   output logic                         flush_o,
`ifdef BRANCH_STATS_EN
   output logic [31:0]                  retired_count_o,
   output logic [31:0]                  mispredict_count_o,
`endif
   output logic [$clog2(TAG_DEPTH):0]   pending_o
);

   localparam int TW = $clog2(TAG_DEPTH);

   seq_state_t    state_q, state_d;
   logic [TW-1:0] head_q, head_d;
   logic [TW-1:0] tail_q, tail_d;
   logic [TW:0]   count_q, count_d;

   branch_entry_t head_entry;
   logic          res_valid, res_resolved;
   logic          alloc_fire, resolve_fire, mispredict, table_clr;

   branch_outcome_sequencer_table #(.TAG_DEPTH(TAG_DEPTH)) u_table (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clr_i          (table_clr),
      .alloc_we_i     (alloc_fire),
      .alloc_idx_i    (tail_q),
      .res_we_i       (resolve_fire),
      .res_idx_i      (resolve_tag_i),
      .res_taken_i    (resolve_taken_i),
      .ret_we_i       (executed_o),
      .head_idx_i     (head_q),
      .head_o         (head_entry),
      .res_valid_o    (res_valid),
      .res_resolved_o (res_resolved)
   );

   // Outputs and accept strobes, all derived from registered state
   always_comb begin
      full_o       = (count_q == (TW+1)'(TAG_DEPTH)) | (state_q == ST_FLUSH);
      flush_o      = (state_q == ST_FLUSH);
      alloc_tag_o  = tail_q;
      pending_o    = count_q;
      executed_o   = (state_q == ST_RUN) & head_entry.valid_alloc & head_entry.resolved;
      taken_o      = head_entry.taken & executed_o;
      alloc_fire   = alloc_i & ~full_o;
      resolve_fire = resolve_i & res_valid & ~res_resolved & (state_q == ST_RUN);
      mispredict   = executed_o & mispredicted_i;
   end

   // FSM next state plus pointer / count update; a mispredict empties everything
   always_comb begin
      state_d   = state_q;
      head_d    = head_q;
      tail_d    = tail_q;
      count_d   = count_q;
      table_clr = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (mispredict) begin
               state_d   = ST_FLUSH;
               head_d    = '0;
               tail_d    = '0;
               count_d   = '0;
               table_clr = 1'b1;
            end else begin
               head_d  = head_q + TW'(executed_o);
               tail_d  = tail_q + TW'(alloc_fire);
               count_d = count_q + (TW+1)'(alloc_fire) - (TW+1)'(executed_o);
            end
         end
         ST_FLUSH: begin
            state_d   = ST_RUN;
            table_clr = 1'b1;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // State, pointer and count registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_RUN;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

`ifdef BRANCH_STATS_EN
   logic [31:0] retired_cnt_q, retired_cnt_d;
   logic [31:0] mispred_cnt_q, mispred_cnt_d;

   // Saturating retire and mispredict counters
   always_comb begin
      retired_cnt_d = retired_cnt_q;
      mispred_cnt_d = mispred_cnt_q;
      if (executed_o && retired_cnt_q != '1) retired_cnt_d = retired_cnt_q + 32'd1;
      if (mispredict && mispred_cnt_q != '1) mispred_cnt_d = mispred_cnt_q + 32'd1;
      retired_count_o    = retired_cnt_q;
      mispredict_count_o = mispred_cnt_q;
   end

   // Counter registers
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         retired_cnt_q <= '0;
         mispred_cnt_q <= '0;
      end else begin
         retired_cnt_q <= retired_cnt_d;
         mispred_cnt_q <= mispred_cnt_d;
      end
   end
`endif

endmodule

// File: tb/tb_branch_outcome_sequencer.sv
// Bench for branch_outcome_sequencer: program-order queue model, directed
// scenarios with literal expectations, then randomized traffic.
module tb_branch_outcome_sequencer;

   localparam int D = 4;

   logic       clk = 1'b0;
   logic       rst_i, alloc_i, resolve_i, resolve_taken_i, mispredicted_i;
   logic [1:0] resolve_tag_i;
   logic [1:0] alloc_tag_o;
   logic       full_o, executed_o, taken_o, flush_o;
   logic [2:0] pending_o;
`ifdef BRANCH_STATS_EN
   logic [31:0] retired_count_o, mispredict_count_o;
`endif

   int n_cmp = 0;
   int n_err = 0;

   // Model: tags in program order, per-tag outcome knowledge, flush flag
   int      ord_q[$];
   bit      m_res[D];
   bit      m_tk[D];
   int      m_next;
   bit      m_flush;
   longint  m_ret, m_mis;

   always #5 clk = ~clk;

   branch_outcome_sequencer #(.TAG_DEPTH(D)) dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .alloc_i         (alloc_i),
      .alloc_tag_o     (alloc_tag_o),
      .full_o          (full_o),
      .resolve_i       (resolve_i),
      .resolve_tag_i   (resolve_tag_i),
      .resolve_taken_i (resolve_taken_i),
      .executed_o      (executed_o),
      .taken_o         (taken_o),
      .mispredicted_i  (mispredicted_i),
      .flush_o         (flush_o),
`ifdef BRANCH_STATS_EN
      .retired_count_o    (retired_count_o),
      .mispredict_count_o (mispredict_count_o),
`endif
      .pending_o       (pending_o)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_flight(input int tag);
      foreach (ord_q[i]) if (ord_q[i] == tag) return 1'b1;
      return 1'b0;
   endfunction

   // One clock cycle: check outputs against the model, drive inputs,
   // advance the model, return #1 after the edge.
   task automatic step(input bit r, input bit a, input bit rs, input int tag,
                       input bit tk, input bit mis);
      int e_pend;
      bit e_full, e_exec, e_tk, do_res;
      @(negedge clk);
      e_pend = ord_q.size();
      e_full = (e_pend == D) || m_flush;
      e_exec = !m_flush && e_pend > 0 && m_res[ord_q[0]];
      e_tk   = e_exec && m_tk[ord_q[0]];
      chk("pending_o", pending_o, e_pend);
      chk("full_o", full_o, e_full);
      chk("alloc_tag_o", alloc_tag_o, m_next);
      chk("executed_o", executed_o, e_exec);
      chk("taken_o", taken_o, e_tk);
      chk("flush_o", flush_o, m_flush);
`ifdef BRANCH_STATS_EN
      chk("retired_count_o", retired_count_o, m_ret);
      chk("mispredict_count_o", mispredict_count_o, m_mis);
`endif
      rst_i           = r;
      alloc_i         = a;
      resolve_i       = rs;
      resolve_tag_i   = 2'(tag);
      resolve_taken_i = tk;
      mispredicted_i  = mis;
      if (r) begin
         ord_q.delete();
         foreach (m_res[i]) begin m_res[i] = 1'b0; m_tk[i] = 1'b0; end
         m_next = 0; m_flush = 1'b0; m_ret = 0; m_mis = 0;
      end else if (m_flush) begin
         m_flush = 1'b0;
      end else begin
         do_res = rs && in_flight(tag) && !m_res[tag];
         if (e_exec) begin
            m_ret++;
            if (mis) m_mis++;
         end
         if (e_exec && mis) begin
            ord_q.delete();
            foreach (m_res[i]) m_res[i] = 1'b0;
            m_next  = 0;
            m_flush = 1'b1;
         end else begin
            if (e_exec) begin
               m_res[ord_q[0]] = 1'b0;
               void'(ord_q.pop_front());
            end
            if (do_res) begin m_res[tag] = 1'b1; m_tk[tag] = tk; end
            if (a && !e_full) begin
               ord_q.push_back(m_next);
               m_res[m_next] = 1'b0;
               m_next = (m_next + 1) % D;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      step(1, 0, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 0);
   endtask

   initial begin
      rst_i = 1'b1; alloc_i = 1'b0; resolve_i = 1'b0; resolve_tag_i = '0;
      resolve_taken_i = 1'b0; mispredicted_i = 1'b0;
      ord_q.delete(); m_next = 0; m_flush = 1'b0; m_ret = 0; m_mis = 0;
      foreach (m_res[i]) begin m_res[i] = 1'b0; m_tk[i] = 1'b0; end

      // Reset state
      do_reset();
      chk("lit_rst_pending", pending_o, 0);
      chk("lit_rst_full", full_o, 0);
      chk("lit_rst_exec", executed_o, 0);
      chk("lit_rst_flush", flush_o, 0);
      chk("lit_rst_tag", alloc_tag_o, 0);

      // In-order: tags 0,1,2 resolved T,N,T on consecutive cycles
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_io_pending", pending_o, 3);
      step(0, 0, 1, 0, 1, 0);
      chk("lit_io_exec0", executed_o, 1);
      chk("lit_io_tk0", taken_o, 1);
      step(0, 0, 1, 1, 0, 0);
      chk("lit_io_exec1", executed_o, 1);
      chk("lit_io_tk1", taken_o, 0);
      step(0, 0, 1, 2, 1, 0);
      chk("lit_io_exec2", executed_o, 1);
      chk("lit_io_tk2", taken_o, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("lit_io_drain", pending_o, 0);

      // Out-of-order: fill, resolve 3,2,1 then 0
      do_reset();
      for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0, 0);
      chk("lit_ooo_full", full_o, 1);
      step(0, 0, 1, 3, 1, 0);
      step(0, 0, 1, 2, 0, 0);
      step(0, 0, 1, 1, 1, 0);
      chk("lit_ooo_noexec", executed_o, 0);
      step(0, 0, 1, 0, 0, 0);
      chk("lit_ooo_exec_n1", executed_o, 1);
      chk("lit_ooo_full_n1", full_o, 1);
      step(0, 0, 0, 0, 0, 0);
      chk("lit_ooo_full_n2", full_o, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0);
      chk("lit_ooo_empty", pending_o, 0);

      // Full drop and alloc during retire
      do_reset();
      for (int i = 0; i < D; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_drop_pending", pending_o, 4);
      chk("lit_drop_tag", alloc_tag_o, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_drop_retire", pending_o, 3);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_drop_accept", pending_o, 4);

      // Mispredict on the tag-0 retire
      do_reset();
      for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 2, 1, 0);
      step(0, 0, 1, 1, 1, 0);
      step(0, 0, 1, 0, 1, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("lit_mp_flush", flush_o, 1);
      chk("lit_mp_pending", pending_o, 0);
      step(0, 1, 1, 1, 0, 0);
      chk("lit_mp_run", full_o, 0);
      chk("lit_mp_tag", alloc_tag_o, 0);
      chk("lit_mp_exec", executed_o, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_mp_alloc", alloc_tag_o, 1);

      // Illegal resolves: unallocated tag and duplicate
      do_reset();
      step(0, 1, 0, 0, 0, 0);
      step(0, 0, 1, 2, 1, 0);
      chk("lit_il_unalloc", executed_o, 0);
      step(0, 0, 1, 0, 1, 0);
      chk("lit_il_exec", executed_o, 1);
      step(0, 0, 1, 0, 0, 0);
      chk("lit_il_dup", executed_o, 0);
      chk("lit_il_pending", pending_o, 0);
      step(0, 0, 0, 0, 0, 0);

      // Reset during FLUSH
      do_reset();
      step(0, 1, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0, 1);
      chk("lit_rf_flush", flush_o, 1);
      step(1, 1, 0, 0, 0, 0);
      chk("lit_rf_flush0", flush_o, 0);
      chk("lit_rf_pending", pending_o, 0);
      chk("lit_rf_tag", alloc_tag_o, 0);
      step(0, 1, 0, 0, 0, 0);
      chk("lit_rf_alloc", pending_o, 1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 2) != 0,
              1'($urandom_range(0, 1)), $urandom_range(0, D - 1),
              1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
      end
      step(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/branch_outcome_sequencer.md
Name: branch_outcome_sequencer

Overview:
- Resolution-side partner of the gshare predictor unit.
- Allocates a tag for every prediction issued by the front end.
- Accepts branch outcomes from the execution stage in any order.
- Replays outcomes to the predictor strictly in program order, at most one per cycle, on the predictor's executed/taken inputs.
- On a misprediction reported by the predictor, emits a one-cycle flush and discards all wrong-path in-flight branches.

Parameters:
- TAG_DEPTH, 4, in-flight branch capacity. Must be a power of 2 and ≥ 2. Matches the predictor FIFO depth.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- alloc_i  in  1  front end issues a prediction this cycle; asserted with the predictor's predict_i
- alloc_tag_o  out  log2(TAG_DEPTH)  tag given to the allocating branch; equals the tail pointer
- full_o  out  1  no free entry, or FLUSH state; front end must stall
- resolve_i  in  1  execution unit resolved a branch
- resolve_tag_i  in  log2(TAG_DEPTH)  tag of the resolved branch
- resolve_taken_i  in  1  actual outcome
- executed_o  out  1  in-order retire strobe to the predictor (executed_i)
- taken_o  out  1  retired outcome to the predictor (taken_i)
- mispredicted_i  in  1  predictor misprediction flag, combinational, same cycle as executed_o
- flush_o  out  1  one-cycle wrong-path flush pulse; also clears the predictor FIFO pointers
- pending_o  out  log2(TAG_DEPTH)+1  number of allocated, not yet retired entries

Behaviour:
- Storage, per entry: valid_alloc, resolved, taken. Pointers: head and tail, log2(TAG_DEPTH) bits each, natural wrap. Count register: log2(TAG_DEPTH)+1 bits.
- Reset (rst_i sampled high at an edge):
  - head = tail = count = 0; all entry bits = 0; state = RUN.
  - executed_o = taken_o = flush_o = full_o = 0; pending_o = 0; alloc_tag_o = 0.
  - Reset wins over every concurrent input.
- States:
  - RUN → FLUSH when executed_o & mispredicted_i (registered).
  - FLUSH → RUN unconditionally after 1 cycle.
- full_o = (count == TAG_DEPTH) | (state == FLUSH). It is derived from registered values only.
- Allocate: when alloc_i & ~full_o, set entry[tail].valid_alloc, clear resolved, then tail+1, count+1. alloc_i while full_o is high is dropped with no state change.
- Resolve: when resolve_i & entry[tag].valid_alloc & ~entry[tag].resolved & state==RUN, set resolved and store taken. Otherwise ignore: unallocated tag, duplicate resolve, or FLUSH state.
- Retire (combinational from registers):
  - executed_o = state==RUN & entry[head].valid_alloc & entry[head].resolved.
  - taken_o = entry[head].taken & executed_o.
  - On executed_o: clear the head entry, head+1, count-1.
- Latency: a resolve of the head entry in cycle N gives executed_o in cycle N+1. Younger resolved entries retire in the following consecutive cycles, one per cycle.
- Simultaneous events:
  - Alloc and retire in the same cycle: count unchanged; both pointers advance.
  - Resolve of the head tag in the same cycle it would retire cannot occur, because retire requires a registered resolved bit.
- Mispredict in cycle M:
  - The head entry still retires in M.
  - Cycle M+1 is FLUSH: flush_o = 1; all entries cleared; head = tail = count = 0; alloc and resolve ignored; executed_o = 0.
  - Cycle M+2 is RUN again with full_o = 0.
- Wrap-around: pointers wrap modulo TAG_DEPTH. Full and empty are distinguished by count only.
- Reset mid-FLUSH or with entries pending: everything returns to the reset values on the next edge.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- Defined: adds two 32-bit outputs, retired_count_o and mispredict_count_o.
  - retired_count_o increments on every executed_o.
  - mispredict_count_o increments on executed_o & mispredicted_i.
  - Both saturate at all-ones and clear on rst_i.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Shared branch package holds:
  - the entry struct (valid_alloc, resolved, taken);
  - the state enum {RUN, FLUSH};
  - localparam BRANCH_TAG_BITS = $clog2(TAG_DEPTH), shared with the predictor FIFO depth.
- One sub-module is natural: outcome_table, holding the per-entry bit arrays with 1 allocate-write port, 1 resolve-write port, 1 head-read port and a synchronous clear.
- Pointer, count and FSM logic stay in the top module.

Test Plan:
- In-order: alloc tags 0,1,2; resolve 0(T),1(N),2(T) one per cycle → executed_o in 3 consecutive cycles, each one cycle after its resolve, with taken_o 1,0,1; pending_o returns to 0.
- Out-of-order: alloc 0..3, full_o=1; resolve 3,2,1 → no executed_o. Resolve 0 at cycle N → executed_o in N+1..N+4 with tags 0..3 in order; full_o drops in N+2.
- Full drop: with 4 pending, alloc_i=1 → alloc_tag_o and pending_o unchanged (4). Alloc in the same cycle as a retire → accepted next cycle only.
- Mispredict: pending tags 0..2 all resolved; mispredicted_i=1 on the tag-0 retire → flush_o=1 one cycle later; pending_o=0; the next alloc returns tag 0; tags 1 and 2 are never retired.
- Illegal resolve: resolve tag 2 when only tag 0 is allocated, then resolve tag 0 twice → a single executed_o; no state corruption.
- Reset mid-FLUSH: assert rst_i during the FLUSH cycle → all outputs 0 next cycle; then alloc succeeds with tag 0.
